// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the req/ready instruction
// memory port and presents fetched words to decode with a one-entry skid
// buffer for back-pressure and a drain state for redirects mid-request.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        instr_valid
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d;
    logic [XLEN-1:0]   pc4_out_q, pc4_out_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [XLEN-1:0]   skid_pc4_q, skid_pc4_d;

    logic              hs;
    logic [XLEN-1:0]   pc_plus4;

    // Next-state, PC, output-register and skid-buffer logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        pc4_out_d    = pc4_out_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        hs           = req_q & imem_ready;
        pc_plus4     = pc_q + XLEN'(4);

        if (rst) begin
            state_d      = FETCH;
            pc_d         = RESET_PC;
            instr_d      = '0;
            pc_out_d     = '0;
            pc4_out_d    = '0;
            valid_d      = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            skid_pc4_d   = '0;
        end else if (redirect) begin
            // Flush; an unanswered request must still complete before refetch.
            instr_d      = '0;
            valid_d      = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            skid_pc4_d   = '0;
            pc_d         = {redirect_pc[31:2], 2'b00};
            state_d      = (req_q & ~imem_ready) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (hs) begin
                        pc_d = pc_plus4;
                        if (!stall) begin
                            instr_d   = imem_rdata;
                            pc_out_d  = pc_q;
                            pc4_out_d = pc_plus4;
                            valid_d   = 1'b1;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_q;
                            skid_pc4_d   = pc_plus4;
                            state_d      = HOLD;
                        end
                    end else if (!stall) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_d      = skid_instr_q;
                        pc_out_d     = skid_pc_q;
                        pc4_out_d    = skid_pc4_q;
                        valid_d      = 1'b1;
                        skid_instr_d = '0;
                        skid_pc_d    = '0;
                        skid_pc4_d   = '0;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        // Memory port is registered; DRAIN keeps the outstanding address.
        req_d  = ~rst & (state_d != HOLD);
        addr_d = (state_d == DRAIN) ? addr_q : pc_d;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        req_q        <= req_d;
        addr_q       <= addr_d;
        instr_q      <= instr_d;
        pc_out_q     <= pc_out_d;
        pc4_out_q    <= pc4_out_d;
        valid_q      <= valid_d;
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
        skid_pc4_q   <= skid_pc4_d;
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign pc_plus4_out = pc4_out_q;
    assign instr_valid  = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage with a transaction-level model of
// the expected fetch-address stream and the in-order consumed instruction stream.
module tb_instr_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_req, imem_ready, instr_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_out, pc_plus4_out;

    always #5 clk = ~clk;

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_out(instr_out),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .instr_valid(instr_valid)
    );

    int checks = 0;
    int errors = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive values chosen by the scenario code.
    bit          d_rst, d_stall, d_redir;
    logic [31:0] d_target;

    // Reference model state.
    logic [31:0] exp_fetch, exp_cons, pend_addr;
    bit          drain, skid_full, mem_busy, pend, chk_rst, chk_flush, chk_hold;
    int          mem_left, mem_mode, mem_wait, consumed;

    // Samples taken at the falling edge.
    logic        s_req, s_ready, s_valid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    // One clock: check outputs, answer memory, drive inputs, then update the model.
    task automatic cycle();
        logic hs;
        @(negedge clk);
        if (chk_rst) begin
            check("rst_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr_out, 32'd0);
            check("rst_pc", pc_out, 32'd0);
            check("rst_pc4", pc_plus4_out, 32'd0);
            check("rst_req", 32'(imem_req), 32'd0);
        end
        if (chk_flush) begin
            check("flush_valid", 32'(instr_valid), 32'd0);
            check("flush_instr", instr_out, 32'd0);
        end
        if (chk_hold) begin
            check("hold_valid", 32'(instr_valid), 32'(s_valid));
            check("hold_instr", instr_out, s_instr);
            check("hold_pc", pc_out, s_pc);
            check("hold_pc4", pc_plus4_out, s_pc4);
        end
        if (skid_full) check("skid_req_low", 32'(imem_req), 32'd0);
        if (pend) begin
            check("hs_req_stable", 32'(imem_req), 32'd1);
            check("hs_addr_stable", imem_addr, pend_addr);
        end
        if (instr_valid === 1'b0) check("bubble_instr", instr_out, 32'd0);

        if (imem_req === 1'b1) begin
            if (!mem_busy) begin
                check("fetch_addr", imem_addr, exp_fetch);
                mem_busy = 1'b1;
                mem_left = (mem_mode == 1) ? int'($urandom_range(0, 3)) : mem_wait;
            end
            imem_ready = (mem_left == 0);
            if (mem_left > 0) mem_left--;
            imem_rdata = imem_ready ? (imem_addr ^ KEY) : $urandom;
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            mem_busy   = 1'b0;
        end
        rst         = d_rst;
        stall       = d_stall;
        redirect    = d_redir;
        redirect_pc = d_target;
        s_req   = imem_req;
        s_ready = imem_ready;
        s_valid = instr_valid;
        s_addr  = imem_addr;
        s_instr = instr_out;
        s_pc    = pc_out;
        s_pc4   = pc_plus4_out;

        @(posedge clk);
        if (d_rst) begin
            exp_fetch = RST_PC;
            exp_cons  = RST_PC;
            drain     = 1'b0;
            skid_full = 1'b0;
            mem_busy  = 1'b0;
            pend      = 1'b0;
            chk_rst   = 1'b1;
            chk_flush = 1'b0;
            chk_hold  = 1'b0;
        end else begin
            hs        = s_req & s_ready;
            chk_rst   = 1'b0;
            chk_flush = d_redir;
            chk_hold  = d_stall & ~d_redir;
            if (s_valid && !d_stall && !d_redir) begin
                check("cons_pc", s_pc, exp_cons);
                check("cons_instr", s_instr, exp_cons ^ KEY);
                check("cons_pc4", s_pc4, exp_cons + 32'd4);
                exp_cons = exp_cons + 32'd4;
                consumed++;
            end
            pend      = s_req & ~s_ready;
            pend_addr = s_addr;
            if (hs) mem_busy = 1'b0;
            if (d_redir) begin
                exp_cons  = {d_target[31:2], 2'b00};
                exp_fetch = {d_target[31:2], 2'b00};
                drain     = pend;
                skid_full = 1'b0;
            end else begin
                if (skid_full && !d_stall) skid_full = 1'b0;
                if (hs) begin
                    if (drain) drain = 1'b0;
                    else begin
                        exp_fetch = exp_fetch + 32'd4;
                        if (d_stall) skid_full = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0;
        d_rst = 1'b1; d_stall = 1'b0; d_redir = 1'b0; d_target = '0;
        exp_fetch = RST_PC; exp_cons = RST_PC; pend_addr = '0;
        drain = 0; skid_full = 0; mem_busy = 0; pend = 0;
        chk_rst = 0; chk_flush = 0; chk_hold = 0;
        mem_left = 0; mem_mode = 0; mem_wait = 0; consumed = 0;

        cycle(); cycle();
        d_rst = 1'b0;

        // Zero-wait start-up: first handshake, one-cycle latency, full throughput.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (s_req && s_ready) found = 1'b1;
        end
        check("first_hs", 32'(found), 32'd1);
        check("pre_valid", 32'(s_valid), 32'd0);
        cycle();
        check("lat_valid", 32'(s_valid), 32'd1);
        check("lat_pc", s_pc, RST_PC);
        check("lat_instr", s_instr, RST_PC ^ KEY);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("tput_valid", 32'(s_valid), 32'd1);
        end

        // Two wait states.
        mem_wait = 2;
        for (int i = 0; i < 18; i++) cycle();

        // Stall aligned with a ready, held four cycles.
        mem_wait = 0;
        for (int i = 0; i < 4; i++) cycle();
        d_stall = 1'b1;
        cycle();
        check("stall_aligned_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) cycle();
        d_stall = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Redirect while a request to 0x20 still has wait cycles left.
        mem_wait = 4;
        d_redir = 1'b1; d_target = 32'h0000_0020;
        cycle();
        d_redir = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (s_req && s_addr == 32'h20 && mem_left >= 2) found = 1'b1;
        end
        check("req_0x20_seen", 32'(found), 32'd1);
        d_redir = 1'b1; d_target = 32'h0000_1003;
        cycle();
        d_redir = 1'b0;
        check("drain_ready_low", 32'(s_ready), 32'd0);
        cycle();
        check("drain_req", 32'(s_req), 32'd1);
        check("drain_addr", s_addr, 32'h0000_0020);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (s_valid) found = 1'b1;
        end
        check("redir_valid_seen", 32'(found), 32'd1);
        check("redir_first_pc", s_pc, 32'h0000_1000);

        // Redirect and stall together with a live output.
        mem_wait = 0;
        for (int i = 0; i < 8; i++) cycle();
        d_stall = 1'b1; d_redir = 1'b1; d_target = 32'h0000_2000;
        cycle();
        check("rs_pre_valid", 32'(s_valid), 32'd1);
        d_redir = 1'b0;
        cycle();
        check("rs_valid", 32'(s_valid), 32'd0);
        check("rs_req", 32'(s_req), 32'd1);
        check("rs_addr", s_addr, 32'h0000_2000);
        cycle(); cycle();
        d_stall = 1'b0;
        cycle();

        // PC wrap at the top of the address space.
        d_redir = 1'b1; d_target = 32'hFFFF_FFFC;
        cycle();
        d_redir = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (s_valid) found = 1'b1;
        end
        check("wrap_valid_seen", 32'(found), 32'd1);
        check("wrap_pc", s_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", s_pc4, 32'h0000_0000);
        cycle();
        check("wrap_next_valid", 32'(s_valid), 32'd1);
        check("wrap_next_pc", s_pc, 32'h0000_0000);

        // Reset while draining.
        mem_wait = 5;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (s_req && mem_left >= 2) found = 1'b1;
        end
        check("pre_drain_found", 32'(found), 32'd1);
        d_redir = 1'b1; d_target = 32'h0000_0500;
        cycle();
        check("rd_ready_low", 32'(s_ready), 32'd0);
        d_redir = 1'b0; d_rst = 1'b1;
        cycle();
        d_rst = 1'b0;
        cycle();
        check("rd_req_low", 32'(s_req), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            cycle();
            if (s_req) found = 1'b1;
        end
        check("rd_req_back", 32'(found), 32'd1);
        check("rd_addr", s_addr, RST_PC);

        // Randomized traffic.
        mem_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            d_rst    = ($urandom_range(0, 199) == 0);
            d_stall  = ($urandom_range(0, 3) == 0);
            d_redir  = ($urandom_range(0, 29) == 0);
            d_target = $urandom;
            cycle();
        end
        d_rst = 1'b0; d_stall = 1'b0; d_redir = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("progress", 32'(consumed > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage directly upstream of the instruction field decoder.
- Owns the program counter and drives a req/ready instruction-memory port.
- Registers each fetched 32-bit word with its PC and PC+4, then presents it to decode with a valid flag.
- Supports decode back-pressure (stall) and branch/jump redirection (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept; hold output registers
- redirect  in  1  branch/jump taken; flush and refetch from redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req  out  1  instruction memory request
- imem_addr  out  32  word-aligned fetch address
- imem_ready  in  1  memory response; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_out  out  32  instruction to decoder
- pc_out  out  32  address of instr_out
- pc_plus4_out  out  32  pc_out+4
- instr_valid  out  1  instr_out holds a live instruction

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; state=FETCH.
  - imem_req=0 for the reset cycle; instr_out=0, pc_out=0, pc_plus4_out=0, instr_valid=0; skid buffer empty.
  - rst overrides every other input.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Handshake: imem_addr stays stable until imem_ready. A response may arrive in the same cycle as the request (zero wait) or any later cycle.
  - ready & !stall & !redirect: next edge loads instr_out=rdata, pc_out=pc, pc_plus4_out=pc+4, instr_valid=1, pc=pc+4; stay in FETCH. Throughput is 1 instruction/cycle at zero wait; fetch-to-output latency is 1 cycle.
  - ready & stall & !redirect: output registers hold. Word, pc and pc+4 go to the one-entry skid buffer; pc=pc+4; go to HOLD.
  - !ready & !stall: instr_valid=0 and instr_out=0 (bubble).
  - !ready & stall: outputs hold.
- HOLD:
  - imem_req=0.
  - While stall=1, outputs and skid buffer hold.
  - When stall=0: skid moves to outputs with instr_valid=1, skid clears, go to FETCH (request resumes the next cycle).
- Redirect (priority over stall and ready, below rst):
  - Outputs flush to instr_valid=0, instr_out=0; skid clears; pc={redirect_pc[31:2],2'b00}.
  - If in FETCH with imem_req=1 and imem_ready=0, a request is outstanding: go to DRAIN. Otherwise go to FETCH.
  - If imem_ready=1 in the redirect cycle, the returned word is discarded.
- DRAIN:
  - imem_req=1 and imem_addr stay at the old address (handshake stability).
  - On imem_ready, discard rdata and go to FETCH with the new pc. instr_valid stays 0.
  - A further redirect in DRAIN overwrites pc and stays in DRAIN.
- Arithmetic: pc+4 is 32-bit modulo; 0xFFFF_FFFC wraps to 0x0000_0000.
- No instruction is ever duplicated or dropped except on redirect or reset.

Test Plan:
- Reset, RESET_PC=0x0040_0000, zero-wait memory returning addr^0xA5A5A5A5 → imem_addr sequence 0x400000, 0x400004, 0x400008, …; instr_valid rises 1 cycle after the first ready; pc_out/instr_out match each address.
- Memory with 2 wait states → imem_addr held 3 cycles per fetch; instr_valid=1 for one cycle per instruction with bubbles (instr_out=0) between.
- stall held 4 cycles asserted in the same cycle as a ready → outputs frozen, imem_req=0 during HOLD. After release, the skid word appears; the next fetch is pc+4 with no loss or duplication.
- redirect to 0x0000_1000 (low bits 2'b11) while a request to 0x20 has 3 wait cycles left → stays in DRAIN with imem_addr=0x20 until ready; the word is discarded; next imem_addr=0x1000; instr_valid stays 0 until the 0x1000 word.
- redirect and stall asserted together with a valid output → instr_valid=0 the next cycle; fetch restarts at the target despite stall.
- pc=0xFFFF_FFFC zero-wait → pc_plus4_out=0, next imem_addr=0x0000_0000. rst asserted mid-DRAIN → imem_req=0 next cycle, pc=RESET_PC.
